hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage core. Every cycle it decides the enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles three cases: load-use hazards in ID, taken-branch redirects resolved in EX, and data-memory wait states signalled by a req/ready handshake in MEM. It sits beside the forwarding units. Store-data-after-load is covered by MEM-stage forwarding and does not stall here. The block also keeps saturating stall and flush counters, and sets a sticky error flag on a memory timeout.

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/load_use_detect.sv | 23 ++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    // Per-cycle pipeline register controls, in one bundle so the priority mux
    // can assign a complete set per case.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
                                        ifid_flush: 1'b1, idex_bubble: 1'b1, memwb_bubble: 1'b1};
    localparam hz_ctrl_t CTL_MEM    = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
                                        ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b1};
    localparam hz_ctrl_t CTL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                        ifid_flush: 1'b1, idex_bubble: 1'b1, memwb_bubble: 1'b0};
    localparam hz_ctrl_t CTL_LU     = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1,
                                        ifid_flush: 1'b0, idex_bubble: 1'b1, memwb_bubble: 1'b0};
    localparam hz_ctrl_t CTL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                        ifid_flush: 1'b0, idex_bubble: 1'b0, memwb_bubble: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: stage operands in, register controls and stats out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [hazard_pkg::REG_ADDR_W-1:0] rs1_IFID;
    logic [hazard_pkg::REG_ADDR_W-1:0] rs2_IFID;
    logic                              uses_rs1_IFID;
    logic                              uses_rs2_IFID;
    logic                              store_flag_IFID;
    logic [hazard_pkg::REG_ADDR_W-1:0] rd_IDEX;
    logic                              load_flag_IDEX;
    logic                              branch_taken_EX;
    logic                              dmem_req_EXMEM;
    logic                              dmem_ready;

    logic                              pc_en;
    logic                              ifid_en;
    logic                              idex_en;
    logic                              exmem_en;
    logic                              ifid_flush;
    logic                              idex_bubble;
    logic                              memwb_bubble;
    logic                              mem_err;
    logic [CNT_W-1:0]                  stall_cnt;
    logic [CNT_W-1:0]                  flush_cnt;

    // Pipeline side: drives stage operands, consumes controls.
    modport master (
        output rs1_IFID, rs2_IFID, uses_rs1_IFID, uses_rs2_IFID, store_flag_IFID,
               rd_IDEX, load_flag_IDEX, branch_taken_EX, dmem_req_EXMEM, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble,
               mem_err, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  rs1_IFID, rs2_IFID, uses_rs1_IFID, uses_rs2_IFID, store_flag_IFID,
               rd_IDEX, load_flag_IDEX, branch_taken_EX, dmem_req_EXMEM, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble,
               mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between the EX load and the ID instruction.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_IFID,
    input  logic [REG_ADDR_W-1:0] rs2_IFID,
    input  logic                  uses_rs1_IFID,
    input  logic                  uses_rs2_IFID,
    input  logic                  store_flag_IFID,
    input  logic [REG_ADDR_W-1:0] rd_IDEX,
    input  logic                  load_flag_IDEX,
    output logic                  lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = uses_rs1_IFID && (rs1_IFID == rd_IDEX);
    // Store data comes through MEM-stage forwarding; only the address operand stalls.
    assign rs2_hit = uses_rs2_IFID && !store_flag_IFID && (rs2_IFID == rd_IDEX);
    assign lu      = load_flag_IDEX && (rd_IDEX != X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage hazard/stall controller: memory-wait FSM, priority control mux, stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hif
);

    localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    hz_state_e         state;
    hz_state_e         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              lu;
    logic              mem_miss;
    logic              ms;
    logic              br_flush;
    logic              lu_stall;
    hz_ctrl_t          ctl;

    load_use_detect u_lud (
        .rs1_IFID        (hif.rs1_IFID),
        .rs2_IFID        (hif.rs2_IFID),
        .uses_rs1_IFID   (hif.uses_rs1_IFID),
        .uses_rs2_IFID   (hif.uses_rs2_IFID),
        .store_flag_IFID (hif.store_flag_IFID),
        .rd_IDEX         (hif.rd_IDEX),
        .load_flag_IDEX  (hif.load_flag_IDEX),
        .lu              (lu)
    );

    assign mem_miss = hif.dmem_req_EXMEM && !hif.dmem_ready;
    // In MEM_WAIT a ready response releases the freeze in the same cycle.
    assign ms       = (state == ERR) || (state == MEM_WAIT && !hif.dmem_ready) ||
                      (state == RUN && mem_miss);
    assign br_flush = hif.branch_taken_EX && !ms;
    assign lu_stall = lu && !ms && !hif.branch_taken_EX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (mem_miss) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (hif.dmem_ready)            state_nxt = RUN;
                else if (wait_cnt == WAIT_LAST) state_nxt = ERR;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    // Priority: reset > memory freeze > branch redirect > load-use.
    always_comb begin
        ctl = CTL_NORMAL;
        if (!rst_n)        ctl = CTL_RESET;
        else if (ms)       ctl = CTL_MEM;
        else if (br_flush) ctl = CTL_BRANCH;
        else if (lu_stall) ctl = CTL_LU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN)           wait_cnt <= '0;
            else if (state == MEM_WAIT) wait_cnt <= wait_cnt + 1'b1;

            if ((ms || lu_stall) && (state != ERR) && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + 1'b1;
            if (br_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hif.pc_en        = ctl.pc_en;
    assign hif.ifid_en      = ctl.ifid_en;
    assign hif.idex_en      = ctl.idex_en;
    assign hif.exmem_en     = ctl.exmem_en;
    assign hif.ifid_flush   = ctl.ifid_flush;
    assign hif.idex_bubble  = ctl.idex_bubble;
    assign hif.memwb_bubble = ctl.memwb_bubble;
    assign hif.mem_err      = (state == ERR);
    assign hif.stall_cnt    = stall_cnt;
    assign hif.flush_cnt    = flush_cnt;

endmodule
